// File: rtl/midi_msg_decoder.sv
// MIDI byte-stream parser: running status, real-time pass-through, SysEx discard,
// channel-voice events delivered through a small valid/ready FIFO.
module midi_msg_decoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OMNI       = 1
) (
  input  logic       CLOCK_25,
  input  logic       reset_reg,
  input  logic       byteready,
  input  logic [7:0] midibyte,
  input  logic [3:0] midi_ch,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [2:0] ev_type,
  output logic [3:0] ev_chan,
  output logic [6:0] ev_d1,
  output logic [6:0] ev_d2,
  output logic       rt_pulse,
  output logic [7:0] rt_byte,
  output logic       ovf
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EW = 21;

  typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StSysex} state_e;

  // Byte capture
  logic       sync1_q, sync2_q, sync3_q, primed_q, armed_q, cap_q;
  logic [7:0] byte_q;

  // armed_q stays low until the synchronized level has been seen low after reset,
  // so a byteready already high at reset release yields no strobe.
  always_ff @(posedge CLOCK_25) begin
    if (reset_reg) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
      cap_q    <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      sync1_q  <= byteready;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      primed_q <= 1'b1;
      armed_q  <= armed_q | (primed_q & ~sync1_q);
      cap_q    <= armed_q & sync2_q & ~sync3_q;
      if (armed_q & sync2_q & ~sync3_q) byte_q <= midibyte;
    end
  end

  // Parser
  state_e     state_q, state_d;
  logic [6:0] stat_q, stat_d, d1_q, d1_d;
  logic       is_rt, is_chst, is_data, one_byte;

  assign is_rt    = cap_q & (byte_q[7:3] == 5'b11111);
  assign is_chst  = cap_q & byte_q[7] & (byte_q[7:4] != 4'hF);
  assign is_data  = cap_q & ~byte_q[7];
  assign one_byte = (stat_q[6:4] == 3'd4) | (stat_q[6:4] == 3'd5);

  always_ff @(posedge CLOCK_25) begin
    if (reset_reg) begin
      state_q <= StIdle;
      stat_q  <= 7'd0;
      d1_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      d1_q    <= d1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    d1_d    = d1_q;
    if (is_chst) begin
      state_d = StWaitD1;
      stat_d  = byte_q[6:0];
    end else if (cap_q & byte_q[7] & ~is_rt) begin
      state_d = (byte_q == 8'hF0) ? StSysex : StIdle;
    end else if (is_data) begin
      unique case (state_q)
        StWaitD1: begin
          d1_d = byte_q[6:0];
          if (!one_byte) state_d = StWaitD2;
        end
        StWaitD2: state_d = StWaitD1;
        default:  ;
      endcase
    end
  end

  logic          push_d, chan_ok;
  logic [6:0]    new_d1, new_d2;
  logic [2:0]    new_type;
  logic [EW-1:0] push_data_d;

  always_comb begin
    new_d1      = one_byte ? byte_q[6:0] : d1_q;
    new_d2      = one_byte ? 7'd0 : byte_q[6:0];
    // Note on with zero velocity is reported as note off.
    new_type    = ((stat_q[6:4] == 3'd1) && (new_d2 == 7'd0)) ? 3'd0 : stat_q[6:4];
    chan_ok     = (OMNI != 0) || (stat_q[3:0] == midi_ch);
    push_d      = is_data & chan_ok &
                  (((state_q == StWaitD1) & one_byte) | (state_q == StWaitD2));
    push_data_d = {new_type, stat_q[3:0], new_d1, new_d2};
  end

  logic          push_q, rt_pulse_q;
  logic [EW-1:0] push_data_q;
  logic [7:0]    rt_byte_q;

  always_ff @(posedge CLOCK_25) begin
    if (reset_reg) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
      rt_pulse_q  <= 1'b0;
      rt_byte_q   <= 8'h00;
    end else begin
      push_q      <= push_d;
      push_data_q <= push_data_d;
      rt_pulse_q  <= is_rt;
      if (is_rt) rt_byte_q <= byte_q;
    end
  end

  // Event FIFO with a registered head stage
  logic [AW:0]   wptr_q, rptr_q, wptr_d, rptr_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] head_q;
  logic          ev_valid_q, ovf_q, full, pop, push_ok, nonempty_d;

  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = ev_valid_q & ev_ready;
  assign push_ok    = push_q & (~full | pop);
  assign wptr_d     = wptr_q + {{AW{1'b0}}, push_ok};
  assign rptr_d     = rptr_q + {{AW{1'b0}}, pop};
  assign nonempty_d = (wptr_d != rptr_d);

  always_ff @(posedge CLOCK_25) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data_q;
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset_reg) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ev_valid_q <= 1'b0;
      head_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ev_valid_q <= nonempty_d;
      // Bypass when the next head is the entry being written this cycle.
      if (nonempty_d) head_q <= (push_ok && (wptr_q == rptr_d)) ? push_data_q
                                                                : mem_q[rptr_d[AW-1:0]];
      if (push_q & full & ~pop) ovf_q <= 1'b1;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_type  = head_q[20:18];
  assign ev_chan  = head_q[17:14];
  assign ev_d1    = head_q[13:7];
  assign ev_d2    = head_q[6:0];
  assign rt_pulse = rt_pulse_q;
  assign rt_byte  = rt_byte_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Scoreboard bench: an OMNI decoder and a channel-3 filtered decoder share one byte stream.
module tb_midi_msg_decoder;

  logic       CLOCK_25 = 1'b0;
  logic       reset_reg, byteready, ev_ready, evf_ready;
  logic [7:0] midibyte;
  logic [3:0] midi_ch_o, midi_ch_f;

  logic       ev_valid, rt_pulse, ovf;
  logic [2:0] ev_type;
  logic [3:0] ev_chan;
  logic [6:0] ev_d1, ev_d2;
  logic [7:0] rt_byte;

  logic       evf_valid, rtf_pulse, ovf_f;
  logic [2:0] evf_type;
  logic [3:0] evf_chan;
  logic [6:0] evf_d1, evf_d2;
  logic [7:0] rtf_byte;

  int checks = 0;
  int errors = 0;

  logic [20:0] evq[$];
  logic [20:0] evfq[$];
  logic [7:0]  rtq[$];

  always #20 CLOCK_25 = ~CLOCK_25;

  midi_msg_decoder #(.FIFO_DEPTH(4), .OMNI(1)) dut (
    .CLOCK_25(CLOCK_25), .reset_reg(reset_reg), .byteready(byteready), .midibyte(midibyte),
    .midi_ch(midi_ch_o), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_chan(ev_chan), .ev_d1(ev_d1), .ev_d2(ev_d2), .rt_pulse(rt_pulse), .rt_byte(rt_byte),
    .ovf(ovf)
  );

  midi_msg_decoder #(.FIFO_DEPTH(4), .OMNI(0)) dut_f (
    .CLOCK_25(CLOCK_25), .reset_reg(reset_reg), .byteready(byteready), .midibyte(midibyte),
    .midi_ch(midi_ch_f), .ev_valid(evf_valid), .ev_ready(evf_ready), .ev_type(evf_type),
    .ev_chan(evf_chan), .ev_d1(evf_d1), .ev_d2(evf_d2), .rt_pulse(rtf_pulse),
    .rt_byte(rtf_byte), .ovf(ovf_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected-event model: every event reaches the OMNI decoder, channel 3 also the filtered one.
  task automatic exp_ev(input logic [2:0] t, input logic [3:0] c, input logic [6:0] a,
                        input logic [6:0] b);
    evq.push_back({t, c, a, b});
    if (c == 4'd3) evfq.push_back({t, c, a, b});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLOCK_25); #1;
    midibyte  = b;
    byteready = 1'b1;
    repeat (100) @(posedge CLOCK_25);
    #1 byteready = 1'b0;
    repeat (30) @(posedge CLOCK_25);
  endtask

  always @(negedge CLOCK_25) begin
    if (ev_valid && ev_ready) begin
      if (evq.size() == 0) check_eq("ev_extra", 32'(evq.size()), 32'd1);
      else check_eq("ev", {11'd0, ev_type, ev_chan, ev_d1, ev_d2}, {11'd0, evq.pop_front()});
    end
    if (evf_valid && evf_ready) begin
      if (evfq.size() == 0) check_eq("evf_extra", 32'(evfq.size()), 32'd1);
      else check_eq("evf", {11'd0, evf_type, evf_chan, evf_d1, evf_d2},
                    {11'd0, evfq.pop_front()});
    end
    if (rt_pulse) begin
      if (rtq.size() == 0) check_eq("rt_extra", 32'(rtq.size()), 32'd1);
      else check_eq("rt", {24'd0, rt_byte}, {24'd0, rtq.pop_front()});
    end
  end

  initial begin
    reset_reg = 1'b1;
    byteready = 1'b1;
    midibyte  = 8'h90;
    ev_ready  = 1'b1;
    evf_ready = 1'b1;
    midi_ch_o = 4'd0;
    midi_ch_f = 4'd3;
    repeat (5) @(posedge CLOCK_25);
    #1 reset_reg = 1'b0;
    @(negedge CLOCK_25);
    check_eq("rst_valid", {31'd0, ev_valid}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    check_eq("rst_head", {11'd0, ev_type, ev_chan, ev_d1, ev_d2}, 32'd0);
    check_eq("rst_rt", {23'd0, rt_pulse, rt_byte}, 32'd0);
    // byteready high across reset release must not be captured
    repeat (100) @(posedge CLOCK_25);
    #1 byteready = 1'b0;
    repeat (30) @(posedge CLOCK_25);
    send_byte(8'h3C);
    send_byte(8'h40);

    // Running status and note-on velocity zero
    exp_ev(3'd1, 4'd0, 7'h3C, 7'h64);
    exp_ev(3'd0, 4'd0, 7'h3C, 7'h00);
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64); send_byte(8'h3C); send_byte(8'h00);

    // Real-time interleave
    rtq.push_back(8'hF8);
    exp_ev(3'd3, 4'd2, 7'h07, 7'h7F);
    send_byte(8'hB2); send_byte(8'h07); send_byte(8'hF8); send_byte(8'h7F);

    // Overflow with consumer stalled
    @(posedge CLOCK_25); #1 ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_ev(3'd4, 4'd5, 7'(i), 7'd0);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'hC5);
      send_byte(8'(i));
    end
    @(negedge CLOCK_25);
    check_eq("ovf_set", {31'd0, ovf}, 32'd1);
    check_eq("ovf_valid", {31'd0, ev_valid}, 32'd1);
    check_eq("ovf_head", {25'd0, ev_d1}, 32'd0);
    @(posedge CLOCK_25); #1 ev_ready = 1'b1;
    repeat (10) @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    check_eq("drain_valid", {31'd0, ev_valid}, 32'd0);

    // SysEx discard and channel filter
    exp_ev(3'd1, 4'd3, 7'h40, 7'h50);
    exp_ev(3'd1, 4'd4, 7'h40, 7'h50);
    send_byte(8'hF0); send_byte(8'h7E); send_byte(8'h10); send_byte(8'hF7);
    send_byte(8'h93); send_byte(8'h40); send_byte(8'h50);
    send_byte(8'h94); send_byte(8'h40); send_byte(8'h50);

    // Pitch bend with an abandoned partial note
    exp_ev(3'd6, 4'd1, 7'h00, 7'h40);
    exp_ev(3'd6, 4'd1, 7'h7F, 7'h7F);
    send_byte(8'hE1); send_byte(8'h00); send_byte(8'h40);
    send_byte(8'h90); send_byte(8'h3C);
    send_byte(8'hE1); send_byte(8'h7F); send_byte(8'h7F);

    // Reset mid-message
    send_byte(8'h90); send_byte(8'h3C);
    @(posedge CLOCK_25); #1 reset_reg = 1'b1;
    @(posedge CLOCK_25); #1 reset_reg = 1'b0;
    @(negedge CLOCK_25);
    check_eq("rst2_ovf", {31'd0, ovf}, 32'd0);
    check_eq("rst2_valid", {31'd0, ev_valid}, 32'd0);
    send_byte(8'h64);
    exp_ev(3'd0, 4'd0, 7'h3C, 7'h40);
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h40);

    repeat (20) @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    check_eq("evq_left", 32'(evq.size()), 32'd0);
    check_eq("evfq_left", 32'(evfq.size()), 32'd0);
    check_eq("rtq_left", 32'(rtq.size()), 32'd0);
    check_eq("ovf_f", {31'd0, ovf_f}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_msg_decoder.md
# midi_msg_decoder

Consumes the raw byte stream from the MIDI UART receiver and turns it into complete, typed channel-voice events for the synth voice and controller logic. It tracks its own running status, passes system real-time bytes straight through, and discards SysEx and system-common traffic. Decoded events go into a small FIFO with a valid/ready handshake toward the downstream consumer.

## Interface
Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.
- OMNI, 1: 1 = emit events on all channels; 0 = emit only events whose channel equals midi_ch.

Ports:
- CLOCK_25  in  1  system clock, 25 MHz.
- reset_reg  in  1  reset; one clock, synchronous, active-high.
- byteready  in  1  receiver byte strobe; level generated in the midi_clk domain, asynchronous to CLOCK_25, high ≥ 100 CLOCK_25 cycles.
- midibyte  in  8  received byte; stable while byteready is high.
- midi_ch  in  4  channel select, used when OMNI=0.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head event when ev_valid & ev_ready.
- ev_type  out  3  0 note off, 1 note on, 2 poly aftertouch, 3 control change, 4 program change, 5 channel aftertouch, 6 pitch bend.
- ev_chan  out  4  MIDI channel.
- ev_d1  out  7  first data byte (note, controller, program, pressure, bend LSB).
- ev_d2  out  7  second data byte (velocity, value, bend MSB); 0 for 1-data-byte messages.
- rt_pulse  out  1  one-cycle strobe for a real-time byte.
- rt_byte  out  8  real-time byte; held until the next rt_pulse.
- ovf  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- byteready passes through a 2-FF synchronizer. A rising-edge detect on the synchronized level gives one capture strobe per byte. midibyte is registered on that strobe.
- Byte classes:
  - 0xF8–0xFF: real-time. Drive rt_pulse and rt_byte. Parser state, running status and partial data stay unchanged.
  - 0x80–0xEF: channel status. Latch status and data count. 0xC0/0xD0 take 1 data byte; all others take 2. Go to WAIT_D1.
  - 0xF0: clear running status, go to SYSEX.
  - 0xF1–0xF7: clear running status, go to IDLE.
  - 0x00–0x7F: data byte, handled by state.
- States:
  - IDLE: data bytes are discarded.
  - WAIT_D1: store d1. For a 1-data-byte message, emit the event and stay in WAIT_D1 (running status). Otherwise go to WAIT_D2.
  - WAIT_D2: store d2, emit the event, return to WAIT_D1 (running status).
  - SYSEX: data bytes are discarded. Any status byte leaves per the classes above. 0xF7 goes to IDLE.
- A status byte arriving in WAIT_D2 abandons the partial message without emitting it.
- Note on (0x9n) with d2 = 0 is emitted as ev_type 0 with d2 = 0.
- Channel filter (OMNI=0): messages on other channels are fully parsed but not pushed.
- FIFO:
  - A push while full drops the new event and sets ovf.
  - If a push and a pop land in the same cycle while full, the push is accepted and ovf is not set.
  - A pop while empty has no effect.
  - Read and write pointers wrap modulo FIFO_DEPTH. An extra occupancy bit distinguishes full from empty.

## Timing
- Reset values: ev_valid 0, ev_type/ev_chan/ev_d1/ev_d2 0, rt_pulse 0, rt_byte 0, ovf 0. Parser goes to IDLE, running status cleared, FIFO emptied, synchronizer cleared to 0.
- Reset asserted mid-message discards the partial message. The first data byte after reset is ignored until a new status byte arrives.
- If byteready is already high when reset releases, it produces no strobe; the synchronizer must see a 0→1 transition.
- Capture strobe: cycle 3 after byteready is sampled high (2 sync stages plus the edge register).
- rt_pulse: the cycle after the capture strobe.
- Event push: the cycle after the capture strobe of its last data byte.
- ev_valid: high the cycle after the push into an empty FIFO.
- Head outputs (ev_type..ev_d2) are registered and stable while ev_valid & !ev_ready.
- Pop on a cycle where ev_valid & ev_ready. The next entry appears the following cycle, giving back-to-back throughput of 1 event per cycle.
- Bytes arrive at most every ~8000 cycles, so at most one capture is in flight at a time.

## Test plan
- Running status: bytes 0x90 0x3C 0x64 0x3C 0x00 with ev_ready=1 → two events: {1,0,0x3C,0x64}, then {0,0,0x3C,0x00}.
- Real-time interleave: 0xB2 0x07 0xF8 0x7F → rt_pulse once with rt_byte=0xF8, then one event {3,2,0x07,0x7F}.
- Overflow: ev_ready=0, send six 0xC5 program changes 0x00..0x05 → 4 events held (d1 0x00..0x03), ovf=1. Draining yields 0x00..0x03 in order, then ev_valid=0.
- SysEx and filter, OMNI=0, midi_ch=3: 0xF0 0x7E 0x10 0xF7 0x93 0x40 0x50 0x94 0x40 0x50 → a single event {1,3,0x40,0x50}.
- Pitch bend and abandon: 0xE1 0x00 0x40 0x90 0x3C 0xE1 0x7F 0x7F → {6,1,0x00,0x40}, then {6,1,0x7F,0x7F}; the partial note message produces no event.
- Reset mid-message: 0x90 0x3C, pulse reset_reg one cycle, send 0x64 → no event. Then send 0x80 0x3C 0x40 → {0,0,0x3C,0x40}.
